run_stream_gen: RTL

//  Serial stimulus generator for the run-length detector: turns (bit, length) run commands into a 1-bit

---
 rtl/fsm_pkg.sv | 20 ++
 rtl/run_window.sv | 24 ++
 rtl/run_stream_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared constants and types for the run stream generator and its window predictor.
// Holds the state codes, window preload value and the optional LFSR parameters.
package fsm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Preload mixes 0s and 1s so the predictor cannot flag a run right after reset.
    localparam logic [3:0] WIN_RESET  = 4'b0101;
    localparam logic [3:0] LFSR_SEED  = 4'b1001;
    // Feedback taps for x^4 + x^3 + 1, Fibonacci form shifting toward bit 3.
    localparam logic [3:0] LFSR_TAPS  = 4'b1100;

    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/run_window.sv
// Four-bit history of the serial stream; flags a window of four equal bits.
// Latency: expect_z registers the compare of the previous window, matching the detector's timing.
module run_window
    import fsm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic expect_z
);

    logic [3:0] win;

    always_ff @(posedge clk) begin
        if (!reset) begin
            win      <= WIN_RESET;
            expect_z <= 1'b0;
        end else begin
            win      <= {win[2:0], w};
            expect_z <= (win == 4'b0000) | (win == 4'b1111);
        end
    end

endmodule

// File: rtl/run_stream_gen.sv
// Turns (bit, length) run commands into a serial stream w and predicts the run detector's z.
// Latency: first run bit on w one edge after acceptance; back-to-back runs without a gap.
// Backpressure: cmd_ready only in IDLE or on the last bit of a run. RUN_STREAM_GEN_LFSR_EN adds an idle LFSR.
module run_stream_gen
    import fsm_pkg::*;
#(
    parameter int   LEN_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    output logic             w,
    output logic             w_active,
    output logic [LEN_W-1:0] run_left,
    output logic             expect_z
);

    state_t           state;
    state_t           state_nxt;
    logic             w_nxt;
    logic             active_nxt;
    logic [LEN_W-1:0] left_nxt;
    logic             last_bit;
    logic             accept;
    logic             load;
    logic             idle_w;

    assign last_bit  = (run_left == LEN_W'(1));
    assign cmd_ready = reset & ((state == ST_IDLE) | last_bit);
    assign accept    = cmd_valid & cmd_ready;
    // A zero-length command is consumed but never enters EMIT.
    assign load      = accept & (cmd_len != '0);

`ifdef RUN_STREAM_GEN_LFSR_EN
    logic [3:0] lfsr;

    assign idle_w = lfsr[3];

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (state == ST_IDLE) begin
            lfsr <= lfsr_next(lfsr);
        end
    end
`else
    assign idle_w = IDLE_BIT;
`endif

    always_comb begin
        state_nxt  = state;
        w_nxt      = w;
        active_nxt = w_active;
        left_nxt   = run_left;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nxt  = ST_EMIT;
                    w_nxt      = cmd_bit;
                    active_nxt = 1'b1;
                    left_nxt   = cmd_len;
                end else begin
                    w_nxt = idle_w;
                end
            end
            ST_EMIT: begin
                if (last_bit) begin
                    if (load) begin
                        w_nxt    = cmd_bit;
                        left_nxt = cmd_len;
                    end else begin
                        state_nxt  = ST_IDLE;
                        w_nxt      = idle_w;
                        active_nxt = 1'b0;
                        left_nxt   = '0;
                    end
                end else if (run_left != '0) begin
                    left_nxt = run_left - LEN_W'(1);
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                w_nxt      = idle_w;
                active_nxt = 1'b0;
                left_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            w        <= IDLE_BIT;
            w_active <= 1'b0;
            run_left <= '0;
        end else begin
            state    <= state_nxt;
            w        <= w_nxt;
            w_active <= active_nxt;
            run_left <= left_nxt;
        end
    end

    run_window u_window (
        .clk      (clk),
        .reset    (reset),
        .w        (w),
        .expect_z (expect_z)
    );

endmodule
